// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the operation encodings, the control FSM state type, the iteration
// count of the radix-2 datapath, the divide-by-zero quotient and small
// decode helpers used by mult_div_unit.
package mdu_pkg;

    // Operation encodings as presented on the op port
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    // One radix-2 step per result bit
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    // Quotient reported when the divisor is zero (any operand signs)
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Divide operations have op[1] set
    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    // Signed operations (MULT, DIV) have op[0] clear
    function automatic logic op_is_signed(input logic [1:0] op_v);
        return ~op_v[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, purely combinational.
// Used both to take operand magnitudes before the unsigned iteration and to
// restore the sign of the product, quotient and remainder afterwards.
//   value  : input word
//   negate : 1 -> result = -value, 0 -> result = value
//   result : output word
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Negate by invert-plus-one when requested, otherwise pass through
    always_comb begin
        result = value;
        if (negate) begin
            result = ~value + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed operations are converted to magnitudes on acceptance, processed by a
// 32-step unsigned shift-add (multiply) or restoring-subtract (divide) loop,
// and sign-corrected once at the end, so latency is fixed at 34 edges.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op, a, b : operation request (sampled in IDLE only)
//   mthi, mtlo      : write wdata into HI / LO while idle
//   wdata           : data for mthi / mtlo
//   busy            : operation in progress
//   done            : one-cycle pulse when HI/LO hold the new result
//   hi, lo          : architectural HI / LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    // Control state
    state_e              state_r;
    state_e              next_state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                load_s;
    logic                step_s;
    logic                finish_s;
    logic                move_en_s;

    // Operation context latched at acceptance
    logic                is_div_r;
    logic                neg_res_r;   // product or quotient must be negated
    logic                neg_rem_r;   // remainder must be negated (dividend sign)
    logic                div_zero_r;

    // Iteration datapath: acc_r is the running high half / partial remainder,
    // mq_r holds the multiplier (shifting out) or dividend/quotient.
    logic [WIDTH-1:0]    opb_r;
    logic [WIDTH-1:0]    acc_r;
    logic [WIDTH-1:0]    mq_r;
    logic [WIDTH-1:0]    acc_nxt_s;
    logic [WIDTH-1:0]    mq_nxt_s;

    // Architectural result registers
    logic [WIDTH-1:0]    hi_r;
    logic [WIDTH-1:0]    lo_r;

    // Operand decode and magnitudes
    logic                signed_op_s;
    logic                neg_a_s;
    logic                neg_b_s;
    logic [WIDTH-1:0]    mag_a_s;
    logic [WIDTH-1:0]    mag_b_s;

    // Per-step arithmetic
    logic [WIDTH:0]      mul_sum_s;
    logic [WIDTH:0]      div_shift_s;
    logic                div_ge_s;
    logic [WIDTH-1:0]    div_diff_s;

    // Sign-corrected results
    logic [2*WIDTH-1:0]  prod_fix_s;
    logic [WIDTH-1:0]    quo_fix_s;
    logic [WIDTH-1:0]    rem_fix_s;

    assign signed_op_s = op_is_signed(op);
    assign neg_a_s     = signed_op_s & a[WIDTH-1];
    assign neg_b_s     = signed_op_s & b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (
        .value  (a),
        .negate (neg_a_s),
        .result (mag_a_s)
    );

    mdu_sign_fix #(.W(WIDTH)) u_mag_b (
        .value  (b),
        .negate (neg_b_s),
        .result (mag_b_s)
    );

    // Multiply step: add multiplicand when the current multiplier bit is set.
    // The carry is kept in bit WIDTH so it shifts into the high half.
    assign mul_sum_s = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});

    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract. The partial remainder is always below the divisor, so
    // the difference fits in WIDTH bits whenever the subtraction succeeds.
    assign div_shift_s = {acc_r, mq_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opb_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - opb_r;

    // Next value of the iteration registers for one radix-2 step
    always_comb begin
        acc_nxt_s = acc_r;
        mq_nxt_s  = mq_r;
        if (is_div_r) begin
            if (div_ge_s) begin
                acc_nxt_s = div_diff_s;
                mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = div_shift_s[WIDTH-1:0];
                mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = mul_sum_s[WIDTH:1];
            mq_nxt_s  = {mul_sum_s[0], mq_r[WIDTH-1:1]};
        end
    end

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value  ({acc_r, mq_r}),
        .negate (neg_res_r),
        .result (prod_fix_s)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value  (mq_r),
        .negate (neg_res_r),
        .result (quo_fix_s)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value  (acc_r),
        .negate (neg_rem_r),
        .result (rem_fix_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and per-state control strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        move_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                    move_en_s    = 1'b1;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_ITER) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                finish_s     = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Busy/done flags and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            done_r <= finish_s;
            if (load_s) begin
                busy_r <= 1'b1;
                cnt_r  <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Operand capture at acceptance and one iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            opb_r      <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            mq_r       <= {WIDTH{1'b0}};
        end else if (load_s) begin
            is_div_r   <= op_is_div(op);
            neg_res_r  <= neg_a_s ^ neg_b_s;
            neg_rem_r  <= neg_a_s;
            div_zero_r <= (b == {WIDTH{1'b0}});
            opb_r      <= mag_b_s;
            acc_r      <= {WIDTH{1'b0}};
            mq_r       <= mag_a_s;
        end else if (step_s) begin
            acc_r      <= acc_nxt_s;
            mq_r       <= mq_nxt_s;
        end
    end

    // HI/LO: written only by a finished operation or an idle move
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (finish_s) begin
            if (is_div_r) begin
                hi_r <= rem_fix_s;
                lo_r <= div_zero_r ? DIV0_QUOT : quo_fix_s;
            end else begin
                {hi_r, lo_r} <= prod_fix_s;
            end
        end else begin
            if (move_en_s && mthi) begin
                hi_r <= wdata;
            end
            if (move_en_s && mtlo) begin
                lo_r <= wdata;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed vectors, random
// vectors against a behavioural model, and hand-written sequences for the
// ignored-request, start/move collision and reset-abort cases.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model written from the arithmetic definition
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        int          ix;
        int          iy;
        longint      lx;
        longint      ly;
        ix = x;
        iy = y;
        lx = ix;
        ly = iy;
        case (o)
            2'b00: r = lx * ly;
            2'b01: r = {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Scoreboard: every done pulse consumes one expected {hi,lo}
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk("result", {hi, lo}, e);
            end
        end
    end

    // Issue one operation from a negedge and check latency and busy length
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
        int g;
        int cyc;
        int bcnt;
        g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("idle_before_start", {63'd0, busy}, 64'd0);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        cyc   = 0;
        bcnt  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end while (!done && cyc < 40);
        chk("latency", 64'(cyc), 64'd34);
        chk("busy_cycles", 64'(bcnt), 64'd33);
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    initial begin
        vec_t        tbl[12];
        logic [63:0] pre;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [1:0]  ro;

        tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[4]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        tbl[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[9]  = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        tbl[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_flags", {62'd0, busy, done}, 64'h0);
        reset = 1'b0;

        // Idle moves, both together then HI alone
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h5555_AAAA;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h5555_AAAA, 32'h5555_AAAA});
        mthi  = 1'b1;
        wdata = 32'h1111_2222;
        @(negedge clk);
        mthi  = 1'b0;
        chk("mthi_only", {hi, lo}, {32'h1111_2222, 32'h5555_AAAA});

        // Directed table, issued back-to-back (start in the done cycle)
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});
        end

        // Random vectors against the model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            if (ry == 32'h0) ry = 32'd3;
            run_op(ro, rx, ry, model(ro, rx, ry));
        end

        // start together with mthi/mtlo: start wins, move dropped
        pre   = {hi, lo};
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        exp_q.push_back({32'h0, 32'd15});
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        chk("start_beats_move", {hi, lo}, pre);
        chk("start_accepted", {63'd0, busy}, 64'd1);
        wait_done("collision_done");
        @(negedge clk);

        // Second start and mthi while busy are ignored
        op    = 2'b01;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        exp_q.push_back({32'h0, 32'd42});
        @(negedge clk);
        start = 1'b0;
        pre   = {hi, lo};
        repeat (4) @(negedge clk);
        op    = 2'b01;
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        mthi  = 1'b0;
        chk("no_intermediate", {hi, lo}, pre);
        wait_done("ignore_done");
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        chk("no_second_op", {63'd0, busy}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-run aborts; reset also overrides start/mthi in that cycle
        op    = 2'b01;
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        mthi  = 1'b1;
        wdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("abort_flags", {62'd0, busy, done}, 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        start = 1'b0;
        mthi  = 1'b0;
        @(negedge clk);
        chk("abort_idle", {62'd0, busy, done}, 64'h0);
        mtlo  = 1'b1;
        wdata = 32'h0000_ABCD;
        @(negedge clk);
        mtlo  = 1'b0;
        chk("mtlo_after_reset", {hi, lo}, {32'h0, 32'h0000_ABCD});
        run_op(2'b01, 32'd3, 32'd4, {32'h0, 32'd12});

        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required and verified.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-006 SHALL have port a  input  WIDTH  rs operand (multiplicand or dividend).
REQ-007 SHALL have port b  input  WIDTH  rt operand (multiplier or divisor).
REQ-008 SHALL have port mthi  input  1  write wdata to HI.
REQ-009 SHALL have port mtlo  input  1  write wdata to LO.
REQ-010 SHALL have port wdata  input  WIDTH  data for mthi/mtlo.
REQ-011 SHALL have port busy  output  1  operation in progress; the core stalls mfhi/mflo and new mult/div while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 SHALL have port hi  output  WIDTH  HI register, feeds the mfhi write-back path.
REQ-014 SHALL have port lo  output  WIDTH  LO register, feeds the mflo write-back path.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and FINISH.
REQ-016 IDLE with start=1 at edge E0: latch operand magnitudes, op and result sign; go to RUN with iteration count 0; busy=1 from E0.
REQ-017 RUN: exactly one radix-2 iteration per cycle, shift-add for multiply and restoring subtract for divide; 32 iterations at edges E1..E32, then go to FINISH.
REQ-018 FINISH at edge E33: apply sign fix-up, write HI/LO, set busy=0 and done=1 for exactly one cycle, return to IDLE.
REQ-019 Latency from start to result is fixed at 34 edges regardless of operand values.
REQ-020 A new start is accepted in the cycle done=1, since the FSM is in IDLE.
REQ-021 MULT/MULTU: {hi,lo} = full 64-bit product, two's-complement signed for MULT and unsigned for MULTU.
REQ-022 DIV/DIVU: lo=quotient, hi=remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-023 Divide by zero, any sign: lo=32'hFFFFFFFF, hi=a; same latency; no exception.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-025 start while busy=1 SHALL be ignored; operands and the result are unaffected.
REQ-026 mthi/mtlo in IDLE write HI/LO at the next edge; both may be asserted in the same cycle.
REQ-027 mthi/mtlo while busy=1 SHALL be ignored.
REQ-028 start and mthi/mtlo together in IDLE: start wins; the move is dropped.
REQ-029 hi/lo SHALL change only at FINISH, on an accepted mthi/mtlo, or on reset; intermediate values are never visible.
REQ-030 The operand registers SHALL capture a and b at E0; the core need not hold them stable afterwards.

Reset
REQ-031 reset=1 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration count=0.
REQ-032 Reset in RUN or FINISH SHALL abort the operation; no partial result reaches hi/lo.
REQ-033 reset SHALL take priority over start, mthi and mtlo in the same cycle.

Structure
REQ-034 Shared package mdu_pkg SHALL hold the op encodings, the FSM state enum, ITER=32 and the divide-by-zero quotient constant.
REQ-035 Sub-module mdu_sign_fix SHALL perform conditional two's-complement; it is instanced for operand magnitude and for result correction, with the product negated as 64 bits.
REQ-036 All registers SHALL be in mult_div_unit; mdu_sign_fix is purely combinational.

Verification
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at edge 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-038 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
REQ-039 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-040 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 MULTU 6*7 started, second start (MULTU 2*2) at RUN cycle 5, mthi wdata=0x1234 at RUN cycle 6 -> both ignored; result hi=0, lo=42.
REQ-042 reset at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0; then mtlo wdata=0xABCD in IDLE -> lo=0xABCD at the next edge; a fresh MULTU 3*4 completes normally with lo=12.
